// File: rtl/mine_placer.sv
// Places up to seven mines on a 5x5 board by stepping an LCG modulo 25 and
// rejecting cells that already hold a mine; a run gives up after MAX_TRIES steps.
module mine_placer #(
    parameter int N_CELLS   = 25,
    parameter int MAX_TRIES = 32
) (
    input  logic               in_clka,
    input  logic               in_reset_n,
    input  logic               in_place,
    input  logic [2:0]         in_n_mines,
    input  logic [2:0]         in_mult,
    input  logic [2:0]         in_incr,
    input  logic [4:0]         in_seed,
    output logic [N_CELLS-1:0] out_mines,
    output logic               out_place_done,
    output logic               out_busy,
    output logic               out_error,
    output logic [2:0]         out_mine_cnt,
    output logic [4:0]         out_last_index,
    output logic [1:0]         out_state
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_GEN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [2:0]     n_q, mult_q, incr_q;
    logic [4:0]     seed_q, x_q;
    logic [TW-1:0]  tries_q;

    logic [7:0]     lcg_full;
    logic [4:0]     x_next;
    logic           is_new;
    logic [2:0]     cnt_next;
    logic [TW-1:0]  tries_next;
    logic           gen_fail;
    logic [4:0]     seed_red;

    // The product is formed at 8 bits so the full 7*24+7 range reaches the modulo.
    assign lcg_full   = 8'(mult_q) * 8'(x_q) + 8'(incr_q);
    assign x_next     = 5'(lcg_full % 8'(N_CELLS));
    assign is_new     = ~out_mines[x_next];
    assign cnt_next   = out_mine_cnt + 3'(is_new);
    assign tries_next = tries_q + 1'b1;
    assign seed_red   = (in_seed >= 5'(N_CELLS)) ? in_seed - 5'(N_CELLS) : in_seed;
    assign out_state  = state;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        gen_fail   = 1'b0;
        case (state)
            S_IDLE: if (in_place) state_next = S_INIT;
            S_INIT: state_next = (n_q == 3'd0) ? S_DONE : S_GEN;
            S_GEN: begin
                if (cnt_next == n_q) begin
                    state_next = S_DONE;
                end else if (tries_next == TW'(MAX_TRIES)) begin
                    state_next = S_DONE;
                    gen_fail   = 1'b1;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge in_clka or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state          <= S_IDLE;
            n_q            <= '0;
            mult_q         <= '0;
            incr_q         <= '0;
            seed_q         <= '0;
            x_q            <= '0;
            tries_q        <= '0;
            out_mines      <= '0;
            out_mine_cnt   <= '0;
            out_last_index <= '0;
            out_error      <= 1'b0;
            out_busy       <= 1'b0;
            out_place_done <= 1'b0;
        end else begin
            state          <= state_next;
            out_busy       <= (state_next == S_INIT) || (state_next == S_GEN);
            out_place_done <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (in_place) begin
                        n_q    <= in_n_mines;
                        mult_q <= in_mult;
                        incr_q <= in_incr;
                        seed_q <= seed_red;
                    end
                end
                S_INIT: begin
                    out_mines    <= '0;
                    out_mine_cnt <= '0;
                    out_error    <= 1'b0;
                    tries_q      <= '0;
                    x_q          <= seed_q;
                end
                S_GEN: begin
                    x_q     <= x_next;
                    tries_q <= tries_next;
                    if (is_new) begin
                        out_mines[x_next] <= 1'b1;
                        out_mine_cnt      <= cnt_next;
                        out_last_index    <= x_next;
                    end
                    if (gen_fail) out_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: drivers push expected results, a monitor
// pops and compares on every out_place_done pulse.
module tb_mine_placer;

    logic        in_clka = 1'b0;
    logic        in_reset_n;
    logic        in_place;
    logic [2:0]  in_n_mines, in_mult, in_incr;
    logic [4:0]  in_seed;
    logic [24:0] out_mines;
    logic        out_place_done, out_busy, out_error;
    logic [2:0]  out_mine_cnt;
    logic [4:0]  out_last_index;
    logic [1:0]  out_state;

    mine_placer dut (
        .in_clka        (in_clka),
        .in_reset_n     (in_reset_n),
        .in_place       (in_place),
        .in_n_mines     (in_n_mines),
        .in_mult        (in_mult),
        .in_incr        (in_incr),
        .in_seed        (in_seed),
        .out_mines      (out_mines),
        .out_place_done (out_place_done),
        .out_busy       (out_busy),
        .out_error      (out_error),
        .out_mine_cnt   (out_mine_cnt),
        .out_last_index (out_last_index),
        .out_state      (out_state)
    );

    always #5 in_clka = ~in_clka;

    typedef struct {
        logic [24:0] mines;
        logic [2:0]  cnt;
        logic [4:0]  last;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge in_clka) cyc <= cyc + 1;
    always @(negedge in_clka) if (out_busy) busy_cnt = busy_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge in_clka) begin
        if (in_reset_n && out_place_done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mines",      32'(out_mines),      32'(e.mines));
                check("mine_cnt",   32'(out_mine_cnt),   32'(e.cnt));
                check("last_index", 32'(out_last_index), 32'(e.last));
                check("error",      32'(out_error),      32'(e.err));
                check("done_cycle", 32'(cyc),            32'(e.done_cyc));
            end
        end
    end

    // Drive one request at a negedge; returns the number of the accepting edge.
    task automatic issue(input logic [2:0] n, input logic [2:0] m, input logic [2:0] inc,
                         input logic [4:0] s, output int acc);
        @(negedge in_clka);
        in_n_mines = n;
        in_mult    = m;
        in_incr    = inc;
        in_seed    = s;
        in_place   = 1'b1;
        busy_cnt   = 0;
        acc        = cyc + 1;
    endtask

    task automatic push(input logic [24:0] mines, input logic [2:0] cnt, input logic [4:0] last,
                        input logic err, input int done_cyc);
        exp_t e;
        e.mines = mines; e.cnt = cnt; e.last = last; e.err = err; e.done_cyc = done_cyc;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((q.size() != 0 || out_state != 2'd0) && k < 200) begin
            @(negedge in_clka);
            k++;
        end
        if (k >= 200) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // A full run; lat counts cycles from acceptance to the done cycle.
    task automatic run_place(input string name, input logic [2:0] n, input logic [2:0] m,
                             input logic [2:0] inc, input logic [4:0] s,
                             input logic [24:0] mines, input logic [2:0] cnt,
                             input logic [4:0] last, input logic err, input int lat);
        int acc;
        issue(n, m, inc, s, acc);
        push(mines, cnt, last, err, acc + lat - 1);
        @(negedge in_clka);
        in_place = 1'b0;
        check({name, "_init_state"}, 32'(out_state), 32'd1);
        check({name, "_init_busy"},  32'(out_busy),  32'd1);
        wait_idle(name);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    endtask

    initial begin
        int acc, acc2;
        in_reset_n = 1'b0;
        in_place   = 1'b0;
        in_n_mines = '0;
        in_mult    = '0;
        in_incr    = '0;
        in_seed    = '0;
        #1;
        check("rst_mines", 32'(out_mines),      32'd0);
        check("rst_state", 32'(out_state),      32'd0);
        check("rst_busy",  32'(out_busy),       32'd0);
        check("rst_done",  32'(out_place_done), 32'd0);
        check("rst_error", 32'(out_error),      32'd0);
        check("rst_cnt",   32'(out_mine_cnt),   32'd0);
        check("rst_last",  32'(out_last_index), 32'd0);
        @(negedge in_clka);
        in_reset_n = 1'b1;
        repeat (2) @(negedge in_clka);

        // Mines at 6, 23, 17.
        run_place("basic", 3'd3, 3'd7, 3'd6, 5'd0, 25'h0820040, 3'd3, 5'd17, 1'b0, 5);
        // n = 0: nothing placed, last index untouched by INIT.
        run_place("zero", 3'd0, 3'd5, 3'd3, 5'd9, 25'h0000000, 3'd0, 5'd17, 1'b0, 2);
        // Constant sequence: one mine, then 31 duplicates until the try limit.
        run_place("tries", 3'd2, 3'd1, 3'd0, 5'd0, 25'h0000001, 3'd1, 5'd0, 1'b1, 34);
        // Seed 27 reduces to 2: mines at 8, 7, 3, 12, 23, 17, 18.
        run_place("seed", 3'd7, 3'd4, 3'd0, 5'd27, 25'h0861188, 3'd7, 5'd18, 1'b0, 9);

        // Reset during GEN aborts the run without a done pulse.
        issue(3'd3, 3'd7, 3'd6, 5'd0, acc);
        @(negedge in_clka);
        in_place = 1'b0;
        while (cyc < acc + 2) @(negedge in_clka);
        check("abort_first_mine", 32'(out_mines), 32'h40);
        #2 in_reset_n = 1'b0;
        #1;
        check("abort_mines", 32'(out_mines),      32'd0);
        check("abort_cnt",   32'(out_mine_cnt),   32'd0);
        check("abort_last",  32'(out_last_index), 32'd0);
        check("abort_state", 32'(out_state),      32'd0);
        check("abort_busy",  32'(out_busy),       32'd0);
        @(negedge in_clka);
        in_reset_n = 1'b1;
        repeat (8) @(negedge in_clka);
        check("abort_idle", 32'(out_state), 32'd0);
        run_place("rerun", 3'd3, 3'd7, 3'd6, 5'd0, 25'h0820040, 3'd3, 5'd17, 1'b0, 5);

        // in_place and in_n_mines disturbed mid-run: original operands hold.
        issue(3'd3, 3'd7, 3'd6, 5'd0, acc);
        push(25'h0820040, 3'd3, 5'd17, 1'b0, acc + 4);
        @(negedge in_clka);
        in_place = 1'b0;
        while (cyc < acc + 2) @(negedge in_clka);
        in_place   = 1'b1;
        in_n_mines = 3'd7;
        @(negedge in_clka);
        in_place   = 1'b0;
        in_n_mines = 3'd1;
        wait_idle("midrun");

        // in_place held through DONE starts the next run on the first IDLE edge.
        issue(3'd3, 3'd7, 3'd6, 5'd0, acc);
        acc2 = acc + 6;
        push(25'h0820040, 3'd3, 5'd17, 1'b0, acc + 4);
        push(25'h0820040, 3'd3, 5'd17, 1'b0, acc2 + 4);
        while (cyc < acc2 && cyc < acc + 50) @(negedge in_clka);
        check("hold_restart_state", 32'(out_state), 32'd1);
        in_place = 1'b0;
        wait_idle("hold");

        repeat (3) @(negedge in_clka);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
